// File: rtl/fetch_scheduler.sv
// Warp fetch scheduler: per-warp PC table, round-robin grant over eligible warps,
// and a registered valid/ready output stage toward instruction fetch.
module fetch_scheduler #(
  parameter int NUM_WARPS = 32,
  parameter int PC_W      = 32,
  parameter int WID_W     = $clog2(NUM_WARPS),
  parameter int PC_STEP   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      initialize,
  input  logic [NUM_WARPS*PC_W-1:0] init_pc,
  input  logic [NUM_WARPS-1:0]      warp_mask,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic                      redirect_valid,
  input  logic [WID_W-1:0]          redirect_warp,
  input  logic [PC_W-1:0]           redirect_pc,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [WID_W-1:0]          selected_warp_id,
  output logic [PC_W-1:0]           selected_pc
);

  logic [PC_W-1:0]  pc_tbl_r [NUM_WARPS];
  logic [WID_W-1:0] last_r;
  logic             m_tvalid_r;
  logic [WID_W-1:0] sel_wid_r;
  logic [PC_W-1:0]  sel_pc_r;

  logic             out_free_s;
  logic             issue_s;
  logic [WID_W-1:0] grant_s;
  logic [WID_W-1:0] cand_s;
  logic             found_s;

  assign out_free_s = !m_tvalid_r || m_tready;
  assign s_tready   = out_free_s && !initialize && (warp_mask != {NUM_WARPS{1'b0}});
  assign issue_s    = s_tvalid && s_tready;

  assign m_tvalid         = m_tvalid_r;
  assign selected_warp_id = sel_wid_r;
  assign selected_pc      = sel_pc_r;

  // Round-robin search starting just after the last granted warp; the
  // power-of-two warp count lets the index wrap naturally.
  always_comb begin
    grant_s = {WID_W{1'b0}};
    cand_s  = {WID_W{1'b0}};
    found_s = 1'b0;
    for (int i = 1; i <= NUM_WARPS; i++) begin
      cand_s = last_r + WID_W'(i);
      if (!found_s && warp_mask[cand_s]) begin
        grant_s = cand_s;
        found_s = 1'b1;
      end else begin
        grant_s = grant_s;
      end
    end
  end

  // PC table: initialize, then redirect (wins over the issue increment).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        pc_tbl_r[i] <= {PC_W{1'b0}};
      end
    end else if (initialize) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        pc_tbl_r[i] <= init_pc[i*PC_W +: PC_W];
      end
    end else begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        if (redirect_valid && (redirect_warp == WID_W'(i))) begin
          pc_tbl_r[i] <= redirect_pc;
        end else if (issue_s && (grant_s == WID_W'(i))) begin
          pc_tbl_r[i] <= pc_tbl_r[i] + PC_W'(PC_STEP);
        end else begin
          pc_tbl_r[i] <= pc_tbl_r[i];
        end
      end
    end
  end

  // Output stage and grant pointer; a held output is never disturbed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r     <= WID_W'(NUM_WARPS - 1);
      m_tvalid_r <= 1'b0;
      sel_wid_r  <= {WID_W{1'b0}};
      sel_pc_r   <= {PC_W{1'b0}};
    end else if (initialize) begin
      last_r     <= WID_W'(NUM_WARPS - 1);
      m_tvalid_r <= 1'b0;
    end else if (issue_s) begin
      last_r     <= grant_s;
      m_tvalid_r <= 1'b1;
      sel_wid_r  <= grant_s;
      sel_pc_r   <= pc_tbl_r[grant_s];
    end else if (out_free_s) begin
      m_tvalid_r <= 1'b0;
    end else begin
      m_tvalid_r <= m_tvalid_r;
    end
  end

endmodule

// File: tb/tb_fetch_scheduler.sv
// Directed, table-driven bench for fetch_scheduler (32x32 instance) plus a
// small 2-warp 8-bit instance for the PC wrap case.
module tb_fetch_scheduler;

  localparam int NW = 32;
  localparam int PW = 32;

  typedef struct {
    logic        init;
    logic [31:0] mask;
    logic        sv;
    logic        mr;
    logic        rv;
    logic [4:0]  rw;
    logic [31:0] rpc;
    logic        e_str;
    logic        e_mv;
    logic [4:0]  e_wid;
    logic [31:0] e_pc;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            initialize = 1'b0;
  logic [NW*PW-1:0] init_pc;
  logic [NW-1:0]   warp_mask = '0;
  logic            s_tvalid = 1'b0;
  logic            s_tready;
  logic            redirect_valid = 1'b0;
  logic [4:0]      redirect_warp = '0;
  logic [PW-1:0]   redirect_pc = '0;
  logic            m_tvalid;
  logic            m_tready = 1'b0;
  logic [4:0]      selected_warp_id;
  logic [PW-1:0]   selected_pc;

  logic            initialize8 = 1'b0;
  logic [15:0]     init_pc8 = 16'h00FC;
  logic [1:0]      warp_mask8 = 2'b00;
  logic            s_tvalid8 = 1'b0;
  logic            s_tready8;
  logic            redirect_valid8 = 1'b0;
  logic [0:0]      redirect_warp8 = 1'b0;
  logic [7:0]      redirect_pc8 = 8'h00;
  logic            m_tvalid8;
  logic            m_tready8 = 1'b0;
  logic [0:0]      selected_warp_id8;
  logic [7:0]      selected_pc8;

  int n_pass = 0;
  int n_total = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  fetch_scheduler #(.NUM_WARPS(NW), .PC_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .initialize(initialize), .init_pc(init_pc),
    .warp_mask(warp_mask), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .redirect_valid(redirect_valid), .redirect_warp(redirect_warp),
    .redirect_pc(redirect_pc), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .selected_warp_id(selected_warp_id), .selected_pc(selected_pc)
  );

  fetch_scheduler #(.NUM_WARPS(2), .PC_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .initialize(initialize8), .init_pc(init_pc8),
    .warp_mask(warp_mask8), .s_tvalid(s_tvalid8), .s_tready(s_tready8),
    .redirect_valid(redirect_valid8), .redirect_warp(redirect_warp8),
    .redirect_pc(redirect_pc8), .m_tvalid(m_tvalid8), .m_tready(m_tready8),
    .selected_warp_id(selected_warp_id8), .selected_pc(selected_pc8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic init, input logic [31:0] mask, input logic sv,
                     input logic mr, input logic rv, input logic [4:0] rw,
                     input logic [31:0] rpc, input logic e_str, input logic e_mv,
                     input logic [4:0] e_wid, input logic [31:0] e_pc);
    vec_t v;
    v.init = init; v.mask = mask; v.sv = sv; v.mr = mr; v.rv = rv; v.rw = rw;
    v.rpc = rpc; v.e_str = e_str; v.e_mv = e_mv; v.e_wid = e_wid; v.e_pc = e_pc;
    vecs.push_back(v);
  endtask

  task automatic add_init(input logic rv, input logic [4:0] rw, input logic [31:0] rpc);
    add(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, rv, rw, rpc, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic add_issue(input logic [31:0] mask, input logic [4:0] wid, input logic [31:0] pc);
    add(1'b0, mask, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, wid, pc);
  endtask

  initial begin
    for (int i = 0; i < NW; i++) begin
      init_pc[i*PW +: PW] = 32'h1000 + 32'(4 * i);
    end

    // Full mask sweep: warps 0..31, then warp 0 again with its advanced PC.
    add_init(1'b0, 5'd0, 32'h0);
    for (int k = 0; k < 33; k++) begin
      add_issue(32'hFFFF_FFFF, 5'(k % 32), (k < 32) ? 32'h1000 + 32'(4 * k) : 32'h1004);
    end
    // Two eligible warps alternate.
    add_init(1'b0, 5'd0, 32'h0);
    add_issue(32'h11, 5'd0, 32'h1000);
    add_issue(32'h11, 5'd4, 32'h1010);
    add_issue(32'h11, 5'd0, 32'h1004);
    add_issue(32'h11, 5'd4, 32'h1014);
    add_issue(32'h11, 5'd0, 32'h1008);
    add_issue(32'h11, 5'd4, 32'h1018);
    // Backpressure holds the output and blocks issue.
    add_init(1'b0, 5'd0, 32'h0);
    add_issue(32'hFFFF_FFFF, 5'd0, 32'h1000);
    for (int k = 0; k < 3; k++) begin
      add(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd0, 32'h1000);
    end
    add_issue(32'hFFFF_FFFF, 5'd1, 32'h1004);
    add_issue(32'h1, 5'd0, 32'h1004);
    // Redirect colliding with issue of the same warp.
    add_init(1'b0, 5'd0, 32'h0);
    add_issue(32'hFFFF_FFFF, 5'd0, 32'h1000);
    add_issue(32'hFFFF_FFFF, 5'd1, 32'h1004);
    add(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 5'd2, 32'h8000, 1'b1, 1'b1, 5'd2, 32'h1008);
    add_issue(32'h4, 5'd2, 32'h8000);
    add_issue(32'h4, 5'd2, 32'h8004);
    // Empty mask: no issue, pointer kept, redirect still applied.
    add(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 5'd3, 32'h9000, 1'b0, 1'b0, 5'd0, 32'h0);
    add_issue(32'hFFFF_FFFF, 5'd3, 32'h9000);
    // Redirect during initialize is dropped; idle s_tvalid keeps the pointer.
    add_init(1'b1, 5'd0, 32'hDEAD);
    add_issue(32'hFFFF_FFFF, 5'd0, 32'h1000);
    add(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
    add_issue(32'hFFFF_FFFF, 5'd1, 32'h1004);

    // Reset state.
    #2;
    check("rst.m_tvalid", 32'(m_tvalid), 32'h0);
    check("rst.wid", 32'(selected_warp_id), 32'h0);
    check("rst.pc", selected_pc, 32'h0);
    check("rst.s_tready_empty", 32'(s_tready), 32'h0);
    cycle();
    rst_n = 1'b1;
    cycle();

    foreach (vecs[i]) begin
      initialize     = vecs[i].init;
      warp_mask      = vecs[i].mask;
      s_tvalid       = vecs[i].sv;
      m_tready       = vecs[i].mr;
      redirect_valid = vecs[i].rv;
      redirect_warp  = vecs[i].rw;
      redirect_pc    = vecs[i].rpc;
      #1;
      check($sformatf("vec%0d.s_tready", i), 32'(s_tready), 32'(vecs[i].e_str));
      cycle();
      check($sformatf("vec%0d.m_tvalid", i), 32'(m_tvalid), 32'(vecs[i].e_mv));
      if (vecs[i].e_mv) begin
        check($sformatf("vec%0d.wid", i), 32'(selected_warp_id), 32'(vecs[i].e_wid));
        check($sformatf("vec%0d.pc", i), selected_pc, vecs[i].e_pc);
      end
    end
    initialize = 1'b0; redirect_valid = 1'b0;

    // Asynchronous reset while an output is held under backpressure.
    initialize = 1'b1; cycle(); initialize = 1'b0;
    warp_mask = 32'hFFFF_FFFF; s_tvalid = 1'b1; m_tready = 1'b1;
    cycle(); cycle();
    s_tvalid = 1'b0; m_tready = 1'b0;
    cycle();
    check("hold.m_tvalid", 32'(m_tvalid), 32'h1);
    check("hold.wid", 32'(selected_warp_id), 32'h1);
    check("hold.pc", selected_pc, 32'h1004);
    #2 rst_n = 1'b0;
    #1;
    check("arst.m_tvalid", 32'(m_tvalid), 32'h0);
    check("arst.wid", 32'(selected_warp_id), 32'h0);
    check("arst.pc", selected_pc, 32'h0);
    check("arst.s_tready", 32'(s_tready), 32'h1);
    cycle();
    rst_n = 1'b1;
    initialize = 1'b1; cycle(); initialize = 1'b0;
    s_tvalid = 1'b1; m_tready = 1'b1;
    cycle();
    check("post_rst.wid", 32'(selected_warp_id), 32'h0);
    check("post_rst.pc", selected_pc, 32'h1000);
    s_tvalid = 1'b0;

    // 8-bit PC wrap with a single eligible warp.
    initialize8 = 1'b1; cycle(); initialize8 = 1'b0;
    warp_mask8 = 2'b01; s_tvalid8 = 1'b1; m_tready8 = 1'b1;
    #1;
    check("w8.s_tready", 32'(s_tready8), 32'h1);
    cycle();
    check("w8.pc0", 32'(selected_pc8), 32'hFC);
    check("w8.wid0", 32'(selected_warp_id8), 32'h0);
    cycle();
    check("w8.pc1", 32'(selected_pc8), 32'h00);
    check("w8.wid1", 32'(selected_warp_id8), 32'h0);
    check("w8.m_tvalid", 32'(m_tvalid8), 32'h1);
    s_tvalid8 = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
